// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-ported unified memory between the IF and MEM pipeline
// stages. MEM (the older instruction) has priority; one access is in flight
// at a time, sequenced IDLE -> ISSUE -> WAIT -> DONE. The DONE cycle also
// arbitrates the next grant, so back-to-back accesses take 3 cycles with a
// 1-cycle-ack memory.
//
// Optional feature: define ARB_STARVE_GUARD_EN to bound how many MEM grants
// can pass a waiting IF request (STARVE_MAX) before IF is forced through.
// With the macro undefined the arbiter is strict MEM priority.

module mem_port_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic          Clk,
    input  logic          Reset,

    // instruction-fetch requester
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_done,
    output logic          if_stall,

    // data-memory requester
    input  logic          mem_req,
    input  logic          mem_we,
    input  logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_wdata,
    output logic [DW-1:0] mem_rdata,
    output logic          mem_done,
    output logic          mem_stall,

    // memory handshake
    output logic          ram_req,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata,
    input  logic          ram_ack
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t        state_q,     state_d;
    logic          owner_mem_q, owner_mem_d;   // 1 = MEM owns the access, 0 = IF
    logic          ram_req_q,   ram_req_d;
    logic          ram_we_q,    ram_we_d;
    logic [AW-1:0] ram_addr_q,  ram_addr_d;
    logic [DW-1:0] ram_wdata_q, ram_wdata_d;
    logic [DW-1:0] if_rdata_q,  if_rdata_d;
    logic [DW-1:0] mem_rdata_q, mem_rdata_d;
    logic          if_done_q,   if_done_d;
    logic          mem_done_q,  mem_done_d;

    logic          arb_phase;
    logic          if_req_eff;
    logic          mem_req_eff;
    logic          force_if;
    logic          grant_if;
    logic          grant_mem;
    logic          grant_any;

    // Requests eligible for arbitration. In DONE the owner still holds its
    // request high for the completed access, so that request is masked.
    always_comb begin
        arb_phase   = (state_q == ST_IDLE) || (state_q == ST_DONE);
        if_req_eff  = if_req  & ~((state_q == ST_DONE) & ~owner_mem_q);
        mem_req_eff = mem_req & ~((state_q == ST_DONE) &  owner_mem_q);
    end

`ifdef ARB_STARVE_GUARD_EN
    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] STARVE_LIMIT = CW'(STARVE_MAX);

    logic [CW-1:0] starve_cnt_q, starve_cnt_d;

    // Once IF has been passed over STARVE_MAX times in a row it wins the next grant.
    always_comb begin
        force_if = (starve_cnt_q == STARVE_LIMIT) & if_req_eff;
    end

    // Count MEM grants made while an eligible IF request waits; any IF grant
    // or an uncontested MEM grant restarts the count. The forced IF grant
    // clears the counter before it could pass STARVE_MAX.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (grant_if) begin
            starve_cnt_d = '0;
        end else if (grant_mem) begin
            starve_cnt_d = if_req_eff ? starve_cnt_q + 1'b1 : '0;
        end
    end

    // Starvation counter register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`else
    logic unused_starve_max;

    // Strict MEM priority: IF is never forced ahead of a MEM request.
    always_comb begin
        force_if          = 1'b0;
        unused_starve_max = (STARVE_MAX == 0);
    end
`endif

    // Grant decision: MEM first unless the starvation guard forces IF.
    always_comb begin
        grant_mem = arb_phase & mem_req_eff & ~force_if;
        grant_if  = arb_phase & if_req_eff  & ~grant_mem;
        grant_any = grant_mem | grant_if;
    end

    // Next-state and registered-output logic for the access sequencer.
    always_comb begin
        state_d     = state_q;
        owner_mem_d = owner_mem_q;
        ram_req_d   = 1'b0;
        ram_we_d    = ram_we_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        if_done_d   = 1'b0;
        mem_done_d  = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (grant_any) begin
                    // Latch the winner's command; it is held on the memory
                    // port until the next grant replaces it.
                    state_d     = ST_ISSUE;
                    owner_mem_d = grant_mem;
                    ram_req_d   = 1'b1;
                    ram_we_d    = grant_mem & mem_we;
                    ram_addr_d  = grant_mem ? mem_addr  : if_addr;
                    ram_wdata_d = grant_mem ? mem_wdata : '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_ISSUE: begin
                // ram_req is high during this cycle; ack cannot arrive yet.
                state_d = ST_WAIT;
            end

            ST_WAIT: begin
                if (ram_ack) begin
                    state_d = ST_DONE;
                    if (owner_mem_q) begin
                        mem_done_d = 1'b1;
                        if (!ram_we_q) begin
                            mem_rdata_d = ram_rdata;
                        end
                    end else begin
                        if_done_d  = 1'b1;
                        if_rdata_d = ram_rdata;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer and output registers; reset abandons any in-flight access.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            owner_mem_q <= 1'b0;
            ram_req_q   <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_mem_q <= owner_mem_d;
            ram_req_q   <= ram_req_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
            if_done_q   <= if_done_d;
            mem_done_q  <= mem_done_d;
        end
    end

    // Stalls are combinational so the pipeline releases in the done cycle.
    always_comb begin
        if_stall  = if_req  & ~if_done_q;
        mem_stall = mem_req & ~mem_done_q;
    end

    assign ram_req   = ram_req_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign if_done   = if_done_q;
    assign mem_rdata = mem_rdata_q;
    assign mem_done  = mem_done_q;

endmodule
